// File: rtl/mdu_pkg.sv
// Shared MDU op encodings and latency constants.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam logic [3:0] MULT_CYC = 4'd5;
  localparam logic [3:0] DIV_CYC  = 4'd10;

  function automatic logic is_md_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit: HI/LO registers with fixed-latency mult/div and mfhi/mflo/mthi/mtlo access.
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] out
);

  mdu_op_e            w_op;
  logic               w_start;
  logic signed [63:0] w_sa;
  logic signed [63:0] w_sb;
  logic        [63:0] w_ua;
  logic        [63:0] w_ub;
  logic        [31:0] w_tmp_hi;
  logic        [31:0] w_tmp_lo;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_tmp_hi;
  logic [31:0] r_tmp_lo;
  logic [3:0]  r_cnt;
  logic        r_busy;

  assign w_op    = mdu_op_e'(MDUop);
  assign w_start = is_md_op(w_op) && !req && !r_busy;
  assign start   = w_start;
  assign busy    = r_busy;

  assign w_sa = {{32{A[31]}}, A};
  assign w_sb = {{32{B[31]}}, B};
  assign w_ua = {32'd0, A};
  assign w_ub = {32'd0, B};

  // Result computed at issue; a zero divisor re-latches current HI/LO so commit is a no-op.
  always_comb begin
    w_tmp_hi = r_hi;
    w_tmp_lo = r_lo;
    case (w_op)
      MDU_MULT:  {w_tmp_hi, w_tmp_lo} = w_sa * w_sb;
      MDU_MULTU: {w_tmp_hi, w_tmp_lo} = w_ua * w_ub;
      MDU_DIV: begin
        if (B != '0) begin
          w_tmp_lo = 32'(w_sa / w_sb);
          w_tmp_hi = 32'(w_sa % w_sb);
        end
      end
      MDU_DIVU: begin
        if (B != '0) begin
          w_tmp_lo = 32'(w_ua / w_ub);
          w_tmp_hi = 32'(w_ua % w_ub);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_tmp_hi <= '0;
      r_tmp_lo <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (w_start) begin
      r_tmp_hi <= w_tmp_hi;
      r_tmp_lo <= w_tmp_lo;
      r_cnt    <= (w_op == MDU_MULT || w_op == MDU_MULTU) ? MULT_CYC : DIV_CYC;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_busy <= 1'b0;
        r_hi   <= r_tmp_hi;
        r_lo   <= r_tmp_lo;
      end
    end else if (!req) begin
      if (w_op == MDU_MTHI) r_hi <= A;
      if (w_op == MDU_MTLO) r_lo <= A;
    end
  end

  always_comb begin
    out = '0;
    case (w_op)
      MDU_MFHI: out = r_hi;
      MDU_MFLO: out = r_lo;
      default:  out = '0;
    endcase
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-low reset; clears all state while low.
REQ-003 MDUop  input  4  E-stage op from the control unit, encoded per shared defines: none, mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
REQ-004 A  input  32  forwarded rs value.
REQ-005 B  input  32  forwarded rt value.
REQ-006 req  input  1  exception/interrupt request; when high, suppresses the current E-stage op.
REQ-007 start  output  1  combinational; high when MDUop is mult/multu/div/divu, req=0 and busy=0.
REQ-008 busy  output  1  registered; high while an operation is in flight.
REQ-009 out  output  32  combinational read data: HI for mfhi, LO for mflo, else 0.

Function
REQ-010 The block SHALL hold two 32-bit architectural registers, HI and LO, and one 4-bit down-counter.
REQ-011 On a rising edge with start=1, the block SHALL latch the result into temp_hi/temp_lo, load the counter with 5 (mult/multu) or 10 (div/divu), and set busy.
REQ-012 mult/multu SHALL produce a signed/unsigned 64-bit product: upper 32 bits to HI, lower 32 bits to LO.
REQ-013 div/divu SHALL produce a signed/unsigned quotient to LO and remainder to HI; the remainder sign follows the dividend.
REQ-014 With B=0, div/divu SHALL still run 10 busy cycles and SHALL leave HI/LO unchanged.
REQ-015 On each edge while busy, the counter SHALL decrement; on the edge where it goes 1->0, HI/LO SHALL take temp values and busy SHALL clear.
REQ-016 busy SHALL be high for exactly 5 (mult) or 10 (div) consecutive cycles, starting the cycle after start.
REQ-017 HI/LO SHALL be invisible at out until busy clears; no early result is exposed.
REQ-018 mthi/mtlo SHALL write A into HI/LO at the rising edge when busy=0 and req=0.
REQ-019 A md op, mthi or mtlo presented while busy=1 SHALL be ignored; upstream stall logic uses start|busy.
REQ-020 req=1 SHALL suppress start, mthi and mtlo in that cycle.
REQ-021 req=1 SHALL NOT abort an operation already busy; that operation completes and commits normally.
REQ-022 out SHALL reflect the current HI/LO in the same cycle as mfhi/mflo, including a value committed at the immediately preceding edge.
REQ-023 All arithmetic SHALL be done at 64-bit width; signedness is chosen per op only.

Reset
REQ-024 While reset=0, the block SHALL asynchronously set HI=0, LO=0, temp_hi=0, temp_lo=0, counter=0 and busy=0.
REQ-025 Reset asserted mid-operation SHALL discard the pending result; after reset, out=0 for mfhi and for mflo.
REQ-026 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-027 The MDUop encodings and the latency constants (MULT_CYC=5, DIV_CYC=10) SHALL live in the shared defines.v alongside the existing control encodings.
REQ-028 The block SHALL be a single flat module; no sub-module is warranted.

Verification
REQ-029 mult, A=0xFFFFFFFF, B=2 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu, same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 div, A=-7, B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu, A=7, B=2 -> LO=3, HI=1.
REQ-031 mthi A=0x12345678, then mfhi next cycle -> out=0x12345678; divu with B=0 -> after 10 busy cycles, HI and LO unchanged.
REQ-032 mult with req=1 -> start=0, busy stays 0, HI/LO unchanged; req=1 raised during an active div -> div completes and commits.
REQ-033 reset pulsed low at busy cycle 3 of div -> busy=0 and HI=LO=0 immediately; the next mult starts cleanly.
REQ-034 mtlo presented while busy -> LO unchanged; mflo issued the cycle busy falls -> out shows the new LO.
